// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the RAM write/read controllers: FSM state encoding,
// default geometry and the test pattern so both sides agree on expected data.
`timescale 1ns/1ps
package ram_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRead  = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } ctrl_state_e;

    localparam int unsigned DEF_ADDR_W   = 5;
    localparam int unsigned DEF_DATA_W   = 8;
    localparam int unsigned DEF_DEPTH    = 32;
    localparam int unsigned DEF_RD_LAT   = 2;
    localparam int unsigned DEF_PAT_BASE = 0;

    // Pattern word for an address; caller truncates to its data width, giving the wrap.
    function automatic int unsigned pat_word(input int unsigned addr, input int unsigned base);
        return addr + base;
    endfunction

endpackage

// File: rtl/ram_rd_ctrl_if.sv
// Bus bundle between the read controller and its environment (writer, RAM, consumer).
// master: the controller side; slave: the environment side.
`timescale 1ns/1ps
interface ram_rd_ctrl_if
    import ram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
);
    logic              wr_done;
    logic              ram_rd_en;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_rd_data;
    logic              rd_valid;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              busy;
    logic              rd_done;
    logic              chk_err;
    logic [ADDR_W:0]   err_cnt;

    modport master (
        input  wr_done,
        input  ram_rd_data,
        output ram_rd_en,
        output ram_addr,
        output rd_valid,
        output rd_addr,
        output rd_data,
        output busy,
        output rd_done,
        output chk_err,
        output err_cnt
    );

    modport slave (
        output wr_done,
        output ram_rd_data,
        input  ram_rd_en,
        input  ram_addr,
        input  rd_valid,
        input  rd_addr,
        input  rd_data,
        input  busy,
        input  rd_done,
        input  chk_err,
        input  err_cnt
    );

endinterface

// File: rtl/rd_lat_pipe.sv
// Delays {valid, addr} by RD_LAT cycles so they line up with registered RAM read data.
`timescale 1ns/1ps
module rd_lat_pipe #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned RD_LAT = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              vld_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic              vld_o,
    output logic [ADDR_W-1:0] addr_o
);

    logic [RD_LAT-1:0] vld_q, vld_d;
    logic [ADDR_W-1:0] addr_q [RD_LAT];
    logic [ADDR_W-1:0] addr_d [RD_LAT];

    // Shift one stage per cycle; stage 0 takes the fresh request.
    always_comb begin
        vld_d[0]  = vld_i;
        addr_d[0] = addr_i;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i]  = vld_q[i-1];
            addr_d[i] = addr_q[i-1];
        end
    end

    // Pipe registers; reset flushes any in-flight read.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                addr_q[i] <= '0;
            end
        end else begin
            vld_q  <= vld_d;
            addr_q <= addr_d;
        end
    end

    assign vld_o  = vld_q[RD_LAT-1];
    assign addr_o = addr_q[RD_LAT-1];

endmodule

// File: rtl/ram_rd_ctrl.sv
// Read-side controller for the single-port RAM experiment. On a rising edge of wr_done it
// sweeps addresses 0..DEPTH-1, aligns returned data with its address and, when built with
// RAM_RD_CHECK_EN defined, compares every word to (addr + PAT_BASE) and counts mismatches.
// Without RAM_RD_CHECK_EN the checker is absent and chk_err/err_cnt read 0.
`timescale 1ns/1ps
module ram_rd_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned DEPTH    = DEF_DEPTH,
    parameter int unsigned RD_LAT   = DEF_RD_LAT,
    parameter int unsigned PAT_BASE = DEF_PAT_BASE
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    ram_rd_ctrl_if.master bus
);

    localparam int unsigned CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  LAST_DRAIN = CNT_W'(RD_LAT - 1);

    ctrl_state_e       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  drain_q, drain_d;
    logic              rd_en_q, rd_en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              wr_done_q;
    logic              start;
    logic              pipe_vld;
    logic [ADDR_W-1:0] pipe_addr;

    assign start = bus.wr_done & ~wr_done_q;

    // Next-state and next-output decode; outputs are registered alongside the state.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        drain_d = drain_q;
        rd_en_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRead;
                    addr_d  = '0;
                    rd_en_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            StRead: begin
                busy_d = 1'b1;
                if (addr_q == LAST_ADDR) begin
                    // Hold the last address; no wrap into unused words.
                    state_d = StDrain;
                    drain_d = '0;
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    rd_en_d = 1'b1;
                end
            end
            StDrain: begin
                if (drain_q == LAST_DRAIN) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                end else begin
                    drain_d = drain_q + CNT_W'(1);
                    busy_d  = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM state, address counter and registered outputs; reset aborts any pass.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            drain_q   <= '0;
            rd_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wr_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            drain_q   <= drain_d;
            rd_en_q   <= rd_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            wr_done_q <= bus.wr_done;
        end
    end

    rd_lat_pipe #(
        .ADDR_W (ADDR_W),
        .RD_LAT (RD_LAT)
    ) u_rd_lat_pipe (
        .clk_i  (sys_clk),
        .rst_ni (sys_rst_n),
        .vld_i  (rd_en_q),
        .addr_i (addr_q),
        .vld_o  (pipe_vld),
        .addr_o (pipe_addr)
    );

    assign bus.ram_rd_en = rd_en_q;
    assign bus.ram_addr  = addr_q;
    assign bus.busy      = busy_q;
    assign bus.rd_done   = done_q;
    assign bus.rd_valid  = pipe_vld;
    assign bus.rd_addr   = pipe_addr;
    // RAM output is already registered; gate it so idle cycles read as zero.
    assign bus.rd_data   = pipe_vld ? bus.ram_rd_data : '0;

`ifdef RAM_RD_CHECK_EN
    logic              chk_err_q, chk_err_d;
    logic [ADDR_W:0]   err_cnt_q, err_cnt_d;
    logic [DATA_W-1:0] exp_data;
    logic              mismatch;

    // Pattern compare on each aligned word; results clear when a new pass starts.
    always_comb begin
        exp_data  = DATA_W'(pat_word(32'(pipe_addr), PAT_BASE));
        mismatch  = pipe_vld && (bus.ram_rd_data != exp_data);
        chk_err_d = chk_err_q;
        err_cnt_d = err_cnt_q;
        if ((state_q == StIdle) && start) begin
            chk_err_d = 1'b0;
            err_cnt_d = '0;
        end else if (mismatch) begin
            chk_err_d = 1'b1;
            if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + (ADDR_W+1)'(1);
            end
        end
    end

    // Sticky error flag and saturating mismatch counter.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            chk_err_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            chk_err_q <= chk_err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.chk_err = chk_err_q;
    assign bus.err_cnt = err_cnt_q;
`else
    assign bus.chk_err = 1'b0;
    assign bus.err_cnt = '0;
`endif

endmodule

// File: tb/tb_ram_rd_ctrl.sv
// Self-checking bench for ram_rd_ctrl: one instance at RD_LAT=2/PAT_BASE=0 and one at
// RD_LAT=1/PAT_BASE=8'hF0, each with a behavioural RAM of matching latency.
`timescale 1ns/1ps
module tb_ram_rd_ctrl;
    import ram_ctrl_pkg::*;

    localparam int DEPTH = 32;
    localparam int LAT0  = 2;
    localparam int LAT1  = 1;
    localparam int PAT0  = 0;
    localparam int PAT1  = 240;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;
    always #5 sys_clk = ~sys_clk;

    ram_rd_ctrl_if #(.ADDR_W(5), .DATA_W(8)) bus0 ();
    ram_rd_ctrl_if #(.ADDR_W(5), .DATA_W(8)) bus1 ();

    ram_rd_ctrl #(.ADDR_W(5), .DATA_W(8), .DEPTH(DEPTH), .RD_LAT(LAT0), .PAT_BASE(PAT0)) dut0 (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus0)
    );

    ram_rd_ctrl #(.ADDR_W(5), .DATA_W(8), .DEPTH(DEPTH), .RD_LAT(LAT1), .PAT_BASE(PAT1)) dut1 (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus1)
    );

    // Behavioural RAMs: dut0 sees address+output registers, dut1 output register only.
    logic [7:0] mem0 [DEPTH];
    logic [7:0] mem1 [DEPTH];
    logic [4:0] raddr0 = '0;
    logic [7:0] q0 = '0;
    logic [7:0] q1 = '0;

    always @(posedge sys_clk) begin
        if (bus0.ram_rd_en) raddr0 <= bus0.ram_addr;
        q0 <= mem0[raddr0];
        if (bus1.ram_rd_en) q1 <= mem1[bus1.ram_addr];
    end
    assign bus0.ram_rd_data = q0;
    assign bus1.ram_rd_data = q1;

    int n_checks = 0;
    int n_pass   = 0;

    // Observation layout: {en, addr[4:0], valid, vaddr[4:0], vdata[7:0], busy, done}
    function automatic logic [21:0] obs0();
        return {bus0.ram_rd_en, bus0.ram_addr, bus0.rd_valid, bus0.rd_addr, bus0.rd_data,
                bus0.busy, bus0.rd_done};
    endfunction

    function automatic logic [21:0] obs1();
        return {bus1.ram_rd_en, bus1.ram_addr, bus1.rd_valid, bus1.rd_addr, bus1.rd_data,
                bus1.busy, bus1.rd_done};
    endfunction

    function automatic logic [7:0] mem_at(input int which, input int a);
        if (a < 0 || a >= DEPTH) return 8'h00;
        return (which == 0) ? mem0[a] : mem1[a];
    endfunction

    // Reference for cycle k after start: DEPTH reads, RD_LAT drain cycles, one done cycle.
    function automatic void model(input int k, input int lat, input logic [7:0] d,
                                  output logic [21:0] e, output logic [21:0] m);
        logic en, v, bsy, dn;
        en  = (k >= 0) && (k < DEPTH);
        v   = (k >= lat) && (k < lat + DEPTH);
        bsy = (k >= 0) && (k < DEPTH + lat);
        dn  = (k == DEPTH + lat);
        e = {en, 5'(k), v, 5'(k - lat), d, bsy, dn};
        m = {1'b1, {5{en}}, 1'b1, {5{v}}, {8{v}}, 1'b1, 1'b1};
    endfunction

    // Mismatches the checker should count for one full pass.
    function automatic int exp_errs(input int which, input int pat);
        int n = 0;
        for (int a = 0; a < DEPTH; a++) begin
            logic [7:0] p;
            p = 8'(a + pat);
            if (mem_at(which, a) !== p) n++;
        end
`ifdef RAM_RD_CHECK_EN
        return n;
`else
        return (n > 0) ? 0 : 0;
`endif
    endfunction

    task automatic idle_cycles(input int n);
        bus0.wr_done = 1'b0;
        bus1.wr_done = 1'b0;
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        bus0.wr_done = 1'b0;
        bus1.wr_done = 1'b0;
        #20;
        n_checks++;
        if ({obs0(), bus0.chk_err, bus0.err_cnt} !== 29'd0)
            $display("FAIL reset0: got %h want 0", {obs0(), bus0.chk_err, bus0.err_cnt});
        else n_pass++;
        n_checks++;
        if ({obs1(), bus1.chk_err, bus1.err_cnt} !== 29'd0)
            $display("FAIL reset1: got %h want 0", {obs1(), bus1.chk_err, bus1.err_cnt});
        else n_pass++;
        #1 sys_rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge sys_clk);
            n_checks++;
            if (obs0() !== 22'd0) $display("FAIL post_reset cyc %0d: got %h want 0", k, obs0());
            else n_pass++;
        end
    endtask

    // One full pass on dut0 with the current mem0 contents.
    task automatic test_pass0(input string tag);
        logic [21:0] e, m;
        int ee;
        idle_cycles(2);
        ee = exp_errs(0, PAT0);
        @(negedge sys_clk);
        bus0.wr_done = 1'b1;
        for (int k = 0; k < DEPTH + LAT0 + 3; k++) begin
            @(negedge sys_clk);
            model(k, LAT0, mem_at(0, k - LAT0), e, m);
            n_checks++;
            if ((obs0() & m) !== (e & m))
                $display("FAIL %s cyc %0d: got %h want %h", tag, k, obs0() & m, e & m);
            else n_pass++;
            if (k == 0 || k == DEPTH + LAT0) begin
                logic [6:0] want;
                want = (k == 0) ? 7'd0 : {1'(ee > 0), 6'(ee)};
                n_checks++;
                if ({bus0.chk_err, bus0.err_cnt} !== want)
                    $display("FAIL %s_err cyc %0d: got %h want %h", tag, k,
                             {bus0.chk_err, bus0.err_cnt}, want);
                else n_pass++;
            end
        end
    endtask

    task automatic test_basic();
        for (int a = 0; a < DEPTH; a++) mem0[a] = 8'(a + PAT0);
        test_pass0("basic");
    endtask

    task automatic test_corrupt();
        for (int a = 0; a < DEPTH; a++) mem0[a] = 8'(a + PAT0);
        mem0[5]  = 8'hFF;
        mem0[20] = 8'h00;
        test_pass0("corrupt");
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            for (int a = 0; a < DEPTH; a++)
                mem0[a] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'(a + PAT0);
            test_pass0("random");
        end
    endtask

    // wr_done toggles mid-READ must not restart or extend the pass.
    task automatic test_retrigger();
        logic [21:0] e, m;
        int ta;
        for (int a = 0; a < DEPTH; a++) mem0[a] = 8'(a + PAT0);
        ta = int'($urandom_range(1, 20));
        idle_cycles(2);
        @(negedge sys_clk);
        bus0.wr_done = 1'b1;
        for (int k = 0; k < DEPTH + LAT0 + 6; k++) begin
            @(negedge sys_clk);
            model(k, LAT0, mem_at(0, k - LAT0), e, m);
            n_checks++;
            if ((obs0() & m) !== (e & m))
                $display("FAIL retrigger cyc %0d: got %h want %h", k, obs0() & m, e & m);
            else n_pass++;
            if (k == ta) bus0.wr_done = 1'b0;
            if (k == ta + 3) bus0.wr_done = 1'b1;
        end
    endtask

    // Second start accepted in the first IDLE cycle after rd_done.
    task automatic test_back_to_back();
        logic [21:0] e, m;
        localparam int P = DEPTH + LAT0 + 2;
        for (int a = 0; a < DEPTH; a++) mem0[a] = 8'($urandom);
        idle_cycles(2);
        @(negedge sys_clk);
        bus0.wr_done = 1'b1;
        for (int k = 0; k < 2 * P; k++) begin
            int kk;
            @(negedge sys_clk);
            kk = (k >= P) ? k - P : k;
            model(kk, LAT0, mem_at(0, kk - LAT0), e, m);
            n_checks++;
            if ((obs0() & m) !== (e & m))
                $display("FAIL b2b cyc %0d: got %h want %h", k, obs0() & m, e & m);
            else n_pass++;
            if (k == 1) bus0.wr_done = 1'b0;
            if (k == P - 1) bus0.wr_done = 1'b1;
        end
    endtask

    // Reset in the cycle addr 10 is driven: immediate clear, no rd_done, clean restart.
    task automatic test_reset_mid();
        logic [21:0] e, m;
        for (int a = 0; a < DEPTH; a++) mem0[a] = 8'(a + PAT0);
        mem0[3] = 8'hAA;
        idle_cycles(2);
        @(negedge sys_clk);
        bus0.wr_done = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            @(negedge sys_clk);
            model(k, LAT0, mem_at(0, k - LAT0), e, m);
            n_checks++;
            if ((obs0() & m) !== (e & m))
                $display("FAIL rst_mid cyc %0d: got %h want %h", k, obs0() & m, e & m);
            else n_pass++;
        end
        #2 sys_rst_n = 1'b0;
        bus0.wr_done = 1'b0;
        #1;
        n_checks++;
        if ({obs0(), bus0.chk_err, bus0.err_cnt} !== 29'd0)
            $display("FAIL rst_mid_clear: got %h want 0", {obs0(), bus0.chk_err, bus0.err_cnt});
        else n_pass++;
        @(negedge sys_clk);
        #2 sys_rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge sys_clk);
            n_checks++;
            if (obs0() !== 22'd0) $display("FAIL rst_mid_idle cyc %0d: got %h want 0", k, obs0());
            else n_pass++;
        end
        test_pass0("rst_restart");
    endtask

    // RD_LAT=1 with PAT_BASE=8'hF0: pattern wraps at address 16.
    task automatic test_lat1(input int corrupt);
        logic [21:0] e, m;
        int ee;
        for (int a = 0; a < DEPTH; a++) mem1[a] = 8'(a + PAT1);
        for (int c = 0; c < corrupt; c++) mem1[$urandom_range(0, DEPTH - 1)] = 8'($urandom);
        ee = exp_errs(1, PAT1);
        idle_cycles(2);
        @(negedge sys_clk);
        bus1.wr_done = 1'b1;
        for (int k = 0; k < DEPTH + LAT1 + 3; k++) begin
            @(negedge sys_clk);
            model(k, LAT1, mem_at(1, k - LAT1), e, m);
            n_checks++;
            if ((obs1() & m) !== (e & m))
                $display("FAIL lat1 cyc %0d: got %h want %h", k, obs1() & m, e & m);
            else n_pass++;
            if (k == DEPTH + LAT1) begin
                n_checks++;
                if ({bus1.chk_err, bus1.err_cnt} !== {1'(ee > 0), 6'(ee)})
                    $display("FAIL lat1_err: got %h want %h", {bus1.chk_err, bus1.err_cnt},
                             {1'(ee > 0), 6'(ee)});
                else n_pass++;
            end
        end
    endtask

    initial begin
        for (int a = 0; a < DEPTH; a++) begin
            mem0[a] = 8'(a);
            mem1[a] = 8'(a + PAT1);
        end
        test_reset();
        test_basic();
        test_corrupt();
        test_random();
        test_retrigger();
        test_back_to_back();
        test_reset_mid();
        test_lat1(0);
        test_lat1(3);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
